fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the control unit in the RV32I core.
- Owns the PC register and drives requests to instruction memory. Holds the returned instruction until the decode/execute side acknowledges it.
- On each acknowledge, samples PCSrc and the extended immediate to pick the next PC. Detects misaligned targets and memory timeouts, halting on either.

---
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage of the RV32I core, sitting directly in front of the
// control unit. It owns the program counter, issues requests to instruction
// memory and holds each returned word until decode/execute acknowledges it.
// On every acknowledge it picks the next PC from PCSrc/ImmExt. It stops in
// HALT on a misaligned target or when memory fails to answer in time.
//
// Ports
//   clk          core clock, rising edge
//   rst          asynchronous, active-high reset
//   imem_req     fetch request, high only while fetching
//   imem_addr    fetch address, always equal to pc
//   imem_rdata   instruction word returned by memory
//   imem_rvalid  imem_rdata is valid (may arrive in the same cycle as the request)
//   instr        latched instruction presented to decode
//   instr_valid  instr is valid, high only while issuing
//   instr_ack    decode/execute consumed instr; PCSrc/ImmExt valid this cycle
//   PCSrc        branch taken, from the control unit
//   ImmExt       sign-extended branch offset
//   pc           current program counter
//   pc_plus4     pc + 4, combinational, wraps mod 2^32
//   retired      number of successfully acknowledged instructions
//   halted       high once the unit has stopped
//   fault        00 none, 01 misaligned target, 10 fetch timeout
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        PCSrc,
  input  logic [31:0] ImmExt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired,
  output logic        halted,
  output logic [1:0]  fault
);

  localparam logic [1:0] ST_START = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  // addi x0, x0, 0 -- a harmless word for decode to see before the first fetch.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // The wait counter is compared against the last permitted FETCH cycle, so
  // a TIMEOUT of N gives exactly N request cycles before the bus fault.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  logic [31:0] branch_target;
  logic [31:0] next_pc;
  logic        next_misaligned;
  logic        fetch_timeout;

  // Next-PC datapath. Both candidates wrap naturally in 32 bits; only the
  // low two bits matter for alignment since RV32I without C needs word targets.
  assign pc_plus4        = pc + 32'd4;
  assign branch_target   = pc + ImmExt;
  assign next_pc         = PCSrc ? branch_target : pc_plus4;
  assign next_misaligned = |next_pc[1:0];

  // A response arriving in the final wait cycle still counts, so the timeout
  // only fires when that last cycle passes without imem_rvalid.
  assign fetch_timeout = !imem_rvalid && (wait_cnt == WAIT_LAST);

  // Handshake outputs are decoded straight from the state register so that
  // an asynchronous reset drops them in the same instant state returns to START.
  assign imem_req    = (state == ST_FETCH);
  assign instr_valid = (state == ST_ISSUE);
  assign imem_addr   = pc;

  // Control FSM plus the FETCH wait counter. imem_rvalid is only looked at in
  // FETCH and instr_ack only in ISSUE; everywhere else they are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_START;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        ST_START: begin
          state    <= ST_FETCH;
          wait_cnt <= 8'd0;
        end
        ST_FETCH: begin
          if (imem_rvalid) begin
            state    <= ST_ISSUE;
            wait_cnt <= 8'd0;
          end else if (fetch_timeout) begin
            state <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_ISSUE: begin
          if (instr_ack) begin
            state <= next_misaligned ? ST_HALT : ST_FETCH;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

  // Program counter and retire counter. Both move only on an accepted,
  // aligned acknowledge; a misaligned target leaves pc pointing at the
  // branch that produced it so the fault can be located afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      retired <= 32'd0;
    end else if ((state == ST_ISSUE) && instr_ack && !next_misaligned) begin
      pc      <= next_pc;
      retired <= retired + 32'd1;
    end
  end

  // Instruction holding register. Loaded only when memory answers in FETCH,
  // so it stays stable throughout ISSUE and survives a timeout unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr <= NOP_INSTR;
    end else if ((state == ST_FETCH) && imem_rvalid) begin
      instr <= imem_rdata;
    end
  end

  // Fault status. Registered and written only on the way into HALT, which is
  // the single sticky exit until the next reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault  <= FAULT_NONE;
      halted <= 1'b0;
    end else if ((state == ST_FETCH) && fetch_timeout) begin
      fault  <= FAULT_TIMEOUT;
      halted <= 1'b1;
    end else if ((state == ST_ISSUE) && instr_ack && next_misaligned) begin
      fault  <= FAULT_MISALIGN;
      halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. The main instance runs with RESET_PC=0x100
// and TIMEOUT=4; a second instance starts at 0xFFFF_FFFC to exercise PC wrap.
// Expected fetch addresses are queued when the acknowledge that produces them
// is driven, and popped when the DUT raises its next request.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] MAIN_PC = 32'h0000_0100;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack;
  logic        PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired;
  logic        halted;
  logic [1:0]  fault;

  logic        w_rst;
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_rvalid;
  logic [31:0] w_instr;
  logic        w_instr_valid;
  logic        w_ack;
  logic        w_pcsrc;
  logic [31:0] w_imm;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_retired;
  logic        w_halted;
  logic [1:0]  w_fault;

  int total;
  int bad;
  logic [31:0] exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] model_retired;
  logic [31:0] model_instr;

  fetch_unit #(.RESET_PC(MAIN_PC), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .instr(instr), .instr_valid(instr_valid), .instr_ack(instr_ack),
    .PCSrc(PCSrc), .ImmExt(ImmExt),
    .pc(pc), .pc_plus4(pc_plus4), .retired(retired),
    .halted(halted), .fault(fault)
  );

  fetch_unit #(.RESET_PC(WRAP_PC), .TIMEOUT(16)) dut_wrap (
    .clk(clk), .rst(w_rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .imem_rvalid(w_rvalid),
    .instr(w_instr), .instr_valid(w_instr_valid), .instr_ack(w_ack),
    .PCSrc(w_pcsrc), .ImmExt(w_imm),
    .pc(w_pc), .pc_plus4(w_pc_plus4), .retired(w_retired),
    .halted(w_halted), .fault(w_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive the main instance's inputs; they are held through the next rising edge.
  task automatic applyStimulus(input logic rvalid, input logic [31:0] rdata,
                               input logic ack, input logic src,
                               input logic [31:0] imm);
    imem_rvalid = rvalid;
    imem_rdata  = rdata;
    instr_ack   = ack;
    PCSrc       = src;
    ImmExt      = imm;
  endtask

  task automatic resetMain();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_pc", pc, MAIN_PC);
    checkOutput("rst_instr", instr, NOP);
    checkOutput("rst_retired", retired, 32'd0);
    checkOutput("rst_fault", {30'd0, fault}, 32'd0);
    checkOutput("rst_halted", {31'd0, halted}, 32'd0);
    checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    model_pc      = MAIN_PC;
    model_retired = 32'd0;
    model_instr   = NOP;
    exp_q.delete();
    exp_q.push_back(MAIN_PC);
    rst = 1'b0;
  endtask

  task automatic popAddr(input string tag);
    logic [31:0] expected;
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_q_empty"}, imem_addr, 32'hDEAD_BEEF);
    end else begin
      expected = exp_q.pop_front();
      checkOutput(tag, imem_addr, expected);
    end
  endtask

  // One full instruction: same-cycle rvalid in FETCH, immediate ack in ISSUE.
  task automatic runInstr(input logic [31:0] data, input logic src,
                          input logic [31:0] imm);
    logic [31:0] nxt;
    @(negedge clk);
    checkOutput("fetch_req", {31'd0, imem_req}, 32'd1);
    popAddr("fetch_addr");
    applyStimulus(1'b1, data, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    model_instr = data;
    @(negedge clk);
    checkOutput("issue_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("issue_req", {31'd0, imem_req}, 32'd0);
    checkOutput("issue_instr", instr, model_instr);
    checkOutput("pc_plus4", pc_plus4, model_pc + 32'd4);
    nxt = src ? (model_pc + imm) : (model_pc + 32'd4);
    applyStimulus(1'b0, 32'h0, 1'b1, src, imm);
    if (nxt[1:0] == 2'b00) begin
      model_pc = nxt;
      model_retired = model_retired + 32'd1;
      exp_q.push_back(nxt);
    end
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("post_ack_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("post_ack_retired", retired, model_retired);
    checkOutput("post_ack_pc", pc, model_pc);
    if (nxt[1:0] == 2'b00) begin
      checkOutput("post_ack_req", {31'd0, imem_req}, 32'd1);
      checkOutput("post_ack_fault", {30'd0, fault}, 32'd0);
    end else begin
      checkOutput("mis_halted", {31'd0, halted}, 32'd1);
      checkOutput("mis_fault", {30'd0, fault}, 32'd1);
      checkOutput("mis_req", {31'd0, imem_req}, 32'd0);
    end
  endtask

  initial begin
    int cycles;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    w_rst = 1'b1;
    w_rvalid = 1'b0; w_rdata = 32'h0; w_ack = 1'b0; w_pcsrc = 1'b0; w_imm = 32'h0;

    // ---- wrap instance: 0xFFFF_FFFC + 4 lands on 0 with no fault ----
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    checkOutput("w_rst_pc", w_pc, WRAP_PC);
    w_rst = 1'b0;
    @(negedge clk);
    checkOutput("w_fetch_req", {31'd0, w_req}, 32'd1);
    checkOutput("w_fetch_addr", w_addr, WRAP_PC);
    checkOutput("w_pc_plus4", w_pc_plus4, 32'h0000_0000);
    w_rvalid = 1'b1; w_rdata = 32'h0000_0033;
    @(posedge clk); #1;
    w_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("w_issue_valid", {31'd0, w_instr_valid}, 32'd1);
    w_ack = 1'b1; w_pcsrc = 1'b0;
    @(posedge clk); #1;
    w_ack = 1'b0;
    @(negedge clk);
    checkOutput("w_wrap_addr", w_addr, 32'h0000_0000);
    checkOutput("w_wrap_req", {31'd0, w_req}, 32'd1);
    checkOutput("w_wrap_fault", {30'd0, w_fault}, 32'd0);
    checkOutput("w_wrap_retired", w_retired, 32'd1);
    w_rst = 1'b1;

    // ---- sequential fetch from 0x100 ----
    resetMain();
    runInstr(32'h0010_0093, 1'b0, 32'h0);
    runInstr(32'h0020_0113, 1'b0, 32'h0);
    runInstr(32'h0030_0193, 1'b0, 32'h0);
    checkOutput("seq_retired3", retired, 32'd3);

    // ---- branches: reach 0x200, taken back to 0x1F8, forward, then fall-through ----
    runInstr(32'h0F40_006F, 1'b1, 32'h0000_00F4);
    runInstr(32'hFE00_0CE3, 1'b1, 32'hFFFF_FFF8);
    runInstr(32'h0080_006F, 1'b1, 32'h0000_0008);
    runInstr(32'h0000_0013, 1'b0, 32'hFFFF_FFF8);
    runInstr(32'hE3C0_006F, 1'b1, 32'hFFFF_FE3C);

    // ---- misaligned target from 0x40 ----
    runInstr(32'h0060_0063, 1'b1, 32'h0000_0006);
    checkOutput("mis_pc_kept", pc, 32'h0000_0040);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1, 32'h4);
    end
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("halt_pc", pc, 32'h0000_0040);
    checkOutput("halt_retired", retired, model_retired);
    checkOutput("halt_instr", instr, model_instr);
    checkOutput("halt_req", {31'd0, imem_req}, 32'd0);
    checkOutput("halt_fault", {30'd0, fault}, 32'd1);
    checkOutput("halt_halted", {31'd0, halted}, 32'd1);

    // ---- timeout: no response, four request cycles then bus fault ----
    resetMain();
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) cycles++;
      else break;
    end
    checkOutput("to_req_cycles", cycles, 32'd4);
    checkOutput("to_halted", {31'd0, halted}, 32'd1);
    checkOutput("to_fault", {30'd0, fault}, 32'd2);
    checkOutput("to_instr", instr, NOP);
    checkOutput("to_pc", pc, MAIN_PC);

    // ---- response in the final wait cycle still wins ----
    resetMain();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("late_req", {31'd0, imem_req}, 32'd1);
      if (i == 3) applyStimulus(1'b1, 32'h00A0_0513, 1'b0, 1'b0, 32'h0);
    end
    popAddr("late_addr");
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("late_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("late_instr", instr, 32'h00A0_0513);
    checkOutput("late_fault", {30'd0, fault}, 32'd0);
    checkOutput("late_halted", {31'd0, halted}, 32'd0);

    // ---- reset during FETCH, with a late rvalid still on the bus ----
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    model_pc = MAIN_PC + 32'd4;
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("rf_pre_req", {31'd0, imem_req}, 32'd1);
    checkOutput("rf_pre_addr", imem_addr, model_pc);
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("rf_async_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rf_async_pc", pc, MAIN_PC);
    checkOutput("rf_async_retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("rf_late_rvalid_instr", instr, NOP);
    checkOutput("rf_restart_req", {31'd0, imem_req}, 32'd1);
    checkOutput("rf_restart_addr", imem_addr, MAIN_PC);

    // ---- reset during ISSUE with ack asserted ----
    @(negedge clk);
    applyStimulus(1'b1, 32'h0000_0063, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("ri_pre_valid", {31'd0, instr_valid}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0010);
    rst = 1'b1;
    #1;
    checkOutput("ri_async_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("ri_async_instr", instr, NOP);
    @(negedge clk);
    checkOutput("ri_retired", retired, 32'd0);
    checkOutput("ri_pc", pc, MAIN_PC);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    model_pc = MAIN_PC;
    model_retired = 32'd0;
    exp_q.delete();
    exp_q.push_back(MAIN_PC);
    runInstr(32'h0000_0013, 1'b0, 32'h0);
    checkOutput("ri_resume_retired", retired, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
